// File: rtl/sram_bank_if.sv
// sram_bank_if: request/response bundle between a memory client and sram_bank.
//
// Signals (master = client, slave = sram_bank):
//   addr       word address                          master -> slave
//   read       read request                          master -> slave
//   write      per-lane write enable                 master -> slave
//   DI         write data, lane i at DI[i*BYTES_SIZE +: BYTES_SIZE]
//   ready      bank accepts requests this cycle      slave -> master
//   DO         read data, meaningful when rvalid=1   slave -> master
//   rvalid     one-cycle strobe marking DO valid     slave -> master
//   err        out-of-range report                   slave -> master
//   init_done  clear sweep finished                  slave -> master
//   dbg_state  current FSM state (0 = CLEAR, 1 = RUN)
//
// Handshake: a request is taken on any rising clk edge where ready=1 and
// (read=1 or write!=0). There is no backpressure beyond ready and nothing
// is queued while ready=0. Each accepted read returns exactly one rvalid
// pulse, in request order, after the fixed read latency.
interface sram_bank_if #(
  parameter int BYTES_SIZE     = 8,
  parameter int BYTES_CNT      = 4,
  parameter int WORD_ADDR_BITS = 14
);
  localparam int WORD_SIZE = BYTES_SIZE * BYTES_CNT;

  logic [WORD_ADDR_BITS-1:0] addr;
  logic                      read;
  logic [BYTES_CNT-1:0]      write;
  logic [WORD_SIZE-1:0]      DI;
  logic                      ready;
  logic [WORD_SIZE-1:0]      DO;
  logic                      rvalid;
  logic                      err;
  logic                      init_done;
  logic [0:0]                dbg_state;

  modport master (
    output addr, read, write, DI,
    input  ready, DO, rvalid, err, init_done, dbg_state
  );

  modport slave (
    input  addr, read, write, DI,
    output ready, DO, rvalid, err, init_done, dbg_state
  );
endinterface

// File: rtl/sram_bank.sv
// sram_bank: byte-lane SRAM model used as instruction and data memory of
// the simple-cycle core.
//
// Features:
//   - BYTES_CNT lanes of BYTES_SIZE bits, WORD_CNT words.
//   - Read latency of 1 or 2 cycles with an rvalid strobe; one read per
//     cycle sustained.
//   - Write-first forwarding per lane when a read and a write hit the same
//     word in the same accepted cycle.
//   - Optional post-reset clear sweep (INIT_CLEAR=1); ready stays low until
//     every word has been zeroed.
//   - Out-of-range detection: reads return zero with err alongside rvalid,
//     rejected writes pulse err for one cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   sram_bank_if slave modport (addr/read/write/DI in,
//         ready/DO/rvalid/err/init_done/dbg_state out)
//
// READ_LAT values other than 2 behave as READ_LAT=1.
module sram_bank #(
  parameter int BYTES_SIZE     = 8,
  parameter int BYTES_CNT      = 4,
  parameter int WORD_SIZE      = BYTES_SIZE * BYTES_CNT,
  parameter int WORD_ADDR_BITS = 14,
  parameter int WORD_CNT       = 1 << WORD_ADDR_BITS,
  parameter int READ_LAT       = 1,
  parameter int INIT_CLEAR     = 1
) (
  input logic        clk,
  input logic        rst,
  sram_bank_if.slave bus
);

  // Index width for the storage array; the full address is still used for
  // the range check so aliasing addresses are rejected, not wrapped.
  localparam int AW = (WORD_CNT > 1) ? $clog2(WORD_CNT) : 1;

  // ptr and the range compare are one bit wider than the address so that
  // WORD_CNT = 2^WORD_ADDR_BITS is representable.
  localparam logic [WORD_ADDR_BITS:0] WORD_CNT_V = (WORD_ADDR_BITS+1)'(WORD_CNT);
  localparam logic [WORD_ADDR_BITS:0] LAST_PTR   = (WORD_ADDR_BITS+1)'(WORD_CNT - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

  // --------------------------------------------------------------------
  // Storage (never reset; the optional sweep is the only initialisation)
  // --------------------------------------------------------------------
  logic [WORD_SIZE-1:0] mem [WORD_CNT];

  // --------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------
  logic [0:0]              state;
  logic [0:0]              state_next;
  logic [WORD_ADDR_BITS:0] ptr;
  logic                    ready_q;
  logic                    init_done_q;

  // --------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------
  logic                 in_range;
  logic                 accept;
  logic                 rd_acc;
  logic                 wr_reject;
  logic [AW-1:0]        idx;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] rd_merged;

  // Memory write port
  logic [BYTES_CNT-1:0] mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  // First read stage and the rejected-write pulse
  logic                 r1_valid;
  logic                 r1_err;
  logic [WORD_SIZE-1:0] r1_data;
  logic                 werr;

  assign in_range  = ({1'b0, bus.addr} < WORD_CNT_V);
  assign accept    = ready_q & (bus.read | (|bus.write));
  assign rd_acc    = accept & bus.read;
  // A rejected write only gets its own err pulse when no read accompanies
  // it; with a read, the error is reported together with rvalid instead.
  assign wr_reject = accept & ~bus.read & ~in_range;
  assign idx       = bus.addr[AW-1:0];
  assign rd_word   = mem[idx];

  // Write-first merge: lanes being written this cycle return DI, the rest
  // return the stored word. Out-of-range reads return zero.
  always_comb begin
    rd_merged = '0;
    if (in_range) begin
      for (int i = 0; i < BYTES_CNT; i++) begin
        rd_merged[i*BYTES_SIZE +: BYTES_SIZE] = bus.write[i]
          ? bus.DI[i*BYTES_SIZE +: BYTES_SIZE]
          : rd_word[i*BYTES_SIZE +: BYTES_SIZE];
      end
    end
  end

  // --------------------------------------------------------------------
  // FSM: CLEAR sweeps ptr over every word, RUN serves requests
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (ptr == LAST_PTR) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RESET;
      ptr         <= '0;
      ready_q     <= 1'b0;
      init_done_q <= (INIT_CLEAR == 0);
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) ptr <= ptr + 1'b1;
      // ready is registered so it stays low through reset even when the
      // reset state is already RUN; it rises on the edge that enters RUN.
      ready_q <= (state_next == ST_RUN);
      if (state_next == ST_RUN) init_done_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------
  // Memory write port: sweep has priority, then accepted in-range writes
  // --------------------------------------------------------------------
  always_comb begin
    mem_we    = '0;
    mem_waddr = idx;
    mem_wdata = bus.DI;
    if (state == ST_CLEAR) begin
      mem_we    = '1;
      mem_waddr = ptr[AW-1:0];
      mem_wdata = '0;
    end else if (accept && in_range) begin
      mem_we = bus.write;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES_CNT; i++) begin
      if (mem_we[i]) begin
        mem[mem_waddr][i*BYTES_SIZE +: BYTES_SIZE] <= mem_wdata[i*BYTES_SIZE +: BYTES_SIZE];
      end
    end
  end

  // --------------------------------------------------------------------
  // Read pipeline. The word is captured at the accepting edge, so a read
  // issued the cycle after a write already sees the updated memory.
  // Data registers only load on a valid read so DO holds between strobes.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_valid <= 1'b0;
      r1_err   <= 1'b0;
      r1_data  <= '0;
      werr     <= 1'b0;
    end else begin
      r1_valid <= rd_acc;
      r1_err   <= rd_acc & ~in_range;
      werr     <= wr_reject;
      if (rd_acc) r1_data <= rd_merged;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic                 r2_valid;
      logic                 r2_err;
      logic [WORD_SIZE-1:0] r2_data;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r2_valid <= 1'b0;
          r2_err   <= 1'b0;
          r2_data  <= '0;
        end else begin
          r2_valid <= r1_valid;
          r2_err   <= r1_err;
          if (r1_valid) r2_data <= r1_data;
        end
      end

      assign bus.rvalid = r2_valid;
      assign bus.err    = r2_err | werr;
      assign bus.DO     = r2_data;
    end else begin : g_lat1
      assign bus.rvalid = r1_valid;
      assign bus.err    = r1_err | werr;
      assign bus.DO     = r1_data;
    end
  endgenerate

  assign bus.ready     = ready_q;
  assign bus.init_done = init_done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank: directed plus randomised bench for sram_bank.
// Three instances share clk/rst:
//   dut_a: 16 words, 4-bit address, READ_LAT=1, INIT_CLEAR=1
//   dut_b: 16 words, 5-bit address, READ_LAT=2, INIT_CLEAR=1
//   dut_c: 12 words, 4-bit address, READ_LAT=1, INIT_CLEAR=0
// Reads push {due cycle, err, data} to a per-instance queue; a negedge
// monitor pops and compares when rvalid appears.
module tb_sram_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_bank_if #(.BYTES_SIZE(8), .BYTES_CNT(4), .WORD_ADDR_BITS(4)) ifa ();
  sram_bank_if #(.BYTES_SIZE(8), .BYTES_CNT(4), .WORD_ADDR_BITS(5)) ifb ();
  sram_bank_if #(.BYTES_SIZE(8), .BYTES_CNT(4), .WORD_ADDR_BITS(4)) ifc ();

  sram_bank #(.BYTES_SIZE(8), .BYTES_CNT(4), .WORD_ADDR_BITS(4), .WORD_CNT(16),
              .READ_LAT(1), .INIT_CLEAR(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sram_bank #(.BYTES_SIZE(8), .BYTES_CNT(4), .WORD_ADDR_BITS(5), .WORD_CNT(16),
              .READ_LAT(2), .INIT_CLEAR(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  sram_bank #(.BYTES_SIZE(8), .BYTES_CNT(4), .WORD_ADDR_BITS(4), .WORD_CNT(12),
              .READ_LAT(1), .INIT_CLEAR(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Scoreboard: entry = {due[31:0], err, data[31:0]}
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  logic [64:0] exp_q2[$];
  logic [31:0] mdl [3][16];
  logic [7:0]  werr_flag [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [64:0] qfront(input int d);
    case (d)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic qpush(input int d, input logic [64:0] e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int d, output logic [64:0] e);
    case (d)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic idle_all();
    ifa.addr = '0; ifa.read = 1'b0; ifa.write = '0; ifa.DI = '0;
    ifb.addr = '0; ifb.read = 1'b0; ifb.write = '0; ifb.DI = '0;
    ifc.addr = '0; ifc.read = 1'b0; ifc.write = '0; ifc.DI = '0;
  endtask

  // Drive one request at a negedge, record expectations, return at the
  // next negedge with inputs idle.
  task automatic op(input int d, input logic [4:0] a, input logic rd,
                    input logic [3:0] wr, input logic [31:0] di);
    int          nw;
    int          lat;
    logic        inr;
    logic [31:0] old;
    logic [31:0] rdat;
    nw  = (d == 2) ? 12 : 16;
    lat = (d == 1) ? 2 : 1;
    inr = (int'(a) < nw);
    case (d)
      0:       begin ifa.addr = a[3:0]; ifa.read = rd; ifa.write = wr; ifa.DI = di; end
      1:       begin ifb.addr = a;      ifb.read = rd; ifb.write = wr; ifb.DI = di; end
      default: begin ifc.addr = a[3:0]; ifc.read = rd; ifc.write = wr; ifc.DI = di; end
    endcase
    old  = inr ? mdl[d][a[3:0]] : 32'h0;
    rdat = 32'h0;
    for (int i = 0; i < 4; i++) rdat[i*8 +: 8] = wr[i] ? di[i*8 +: 8] : old[i*8 +: 8];
    if (!inr) rdat = 32'h0;
    if (rd) qpush(d, {32'(cyc + lat), ~inr, rdat});
    if (inr && wr != 4'h0) mdl[d][a[3:0]] = rdat;
    if (!inr && !rd && wr != 4'h0) werr_flag[d][(cyc + 1) % 8] = 1'b1;
    @(negedge clk);
    idle_all();
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int d, input logic rv, input logic er, input logic [31:0] dout);
    logic [64:0] e;
    logic        wexp;
    int          slot;
    slot = cyc % 8;
    wexp = werr_flag[d][slot];
    werr_flag[d][slot] = 1'b0;
    if (rv) begin
      if (qsize(d) == 0) begin
        check($sformatf("d%0d spurious rvalid cyc %0d", d, cyc), 64'(rv), 64'(1'b0));
      end else begin
        qpop(d, e);
        check($sformatf("d%0d rvalid timing", d), 64'(cyc), 64'(e[64:33]));
        check($sformatf("d%0d DO", d), 64'(dout), 64'(e[31:0]));
        check($sformatf("d%0d err with rvalid", d), 64'(er), 64'(e[32] | wexp));
      end
    end else begin
      check($sformatf("d%0d err idle cyc %0d", d, cyc), 64'(er), 64'(wexp));
      if (qsize(d) > 0) begin
        e = qfront(d);
        if (int'(e[64:33]) <= cyc) begin
          qpop(d, e);
          check($sformatf("d%0d missing rvalid cyc %0d", d, cyc), 64'(rv), 64'(1'b1));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.rvalid, ifa.err, ifa.DO);
    mon(1, ifb.rvalid, ifb.err, ifb.DO);
    mon(2, ifc.rvalid, ifc.err, ifc.DO);
  end

  // Waits (bounded) for dut_a's sweep to end; released at a negedge.
  task automatic sweep_wait(input string tag);
    int cnt;
    cnt = 0;
    while (ifa.ready !== 1'b1 && cnt < 100) begin
      cnt++;
      check({tag, " a init_done low"}, 64'(ifa.init_done), 64'(1'b0));
      if (cnt == 16) check({tag, " b ready low"}, 64'(ifb.ready), 64'(1'b0));
      @(negedge clk);
    end
    check({tag, " a clear cycles"}, 64'(cnt), 64'd16);
    check({tag, " a init_done"}, 64'(ifa.init_done), 64'(1'b1));
    check({tag, " b ready"}, 64'(ifb.ready), 64'(1'b1));
    check({tag, " b init_done"}, 64'(ifb.init_done), 64'(1'b1));
    check({tag, " c ready"}, 64'(ifc.ready), 64'(1'b1));
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) mdl[d][w] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) werr_flag[d] = 8'h0;
    idle_all();
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("a ready rst", 64'(ifa.ready), 64'(1'b0));
    check("a init_done rst", 64'(ifa.init_done), 64'(1'b0));
    check("a rvalid rst", 64'(ifa.rvalid), 64'(1'b0));
    check("a DO rst", 64'(ifa.DO), 64'h0);
    check("a err rst", 64'(ifa.err), 64'(1'b0));
    check("b init_done rst", 64'(ifb.init_done), 64'(1'b0));
    check("c ready rst", 64'(ifc.ready), 64'(1'b0));
    check("c init_done rst", 64'(ifc.init_done), 64'(1'b1));

    // test 1: sweep length, then read of a cleared word
    rst = 1'b1;
    sweep_wait("init");
    op(0, 5'd5, 1'b1, 4'h0, 32'h0);
    op(1, 5'd5, 1'b1, 4'h0, 32'h0);

    // test 2: byte masking
    op(0, 5'd3, 1'b0, 4'b1111, 32'hAABBCCDD);
    op(0, 5'd3, 1'b0, 4'b0101, 32'h11223344);
    op(0, 5'd3, 1'b1, 4'h0, 32'h0);

    // test 3: same-cycle read+write, then re-read; DO must hold afterwards
    op(0, 5'd7, 1'b1, 4'b1100, 32'hDEADBEEF);
    op(0, 5'd7, 1'b1, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("a DO hold", 64'(ifa.DO), 64'hDEAD0000);
    check("a rvalid idle", 64'(ifa.rvalid), 64'(1'b0));

    // read-after-write on both latencies
    op(0, 5'd9, 1'b0, 4'hF, 32'hCAFEF00D);
    op(0, 5'd9, 1'b1, 4'h0, 32'h0);
    op(1, 5'd9, 1'b0, 4'hF, 32'h0BADF00D);
    op(1, 5'd9, 1'b1, 4'h0, 32'h0);

    // test 4: latency-2 back-to-back reads
    op(1, 5'd0, 1'b0, 4'hF, 32'h10);
    op(1, 5'd1, 1'b0, 4'hF, 32'h11);
    op(1, 5'd2, 1'b0, 4'hF, 32'h12);
    op(1, 5'd0, 1'b1, 4'h0, 32'h0);
    op(1, 5'd1, 1'b1, 4'h0, 32'h0);
    op(1, 5'd2, 1'b1, 4'h0, 32'h0);
    // latency-2 range edges and a rejected write
    op(1, 5'd15, 1'b1, 4'h0, 32'h0);
    op(1, 5'd16, 1'b1, 4'h0, 32'h0);
    op(1, 5'd20, 1'b0, 4'hF, 32'h77777777);
    op(1, 5'd4, 1'b1, 4'h0, 32'h0);

    // randomised mix against the model
    for (int k = 0; k < 40; k++)
      op(0, 5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), $urandom);
    for (int k = 0; k < 40; k++)
      op(1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), $urandom);

    // test 5: 12-word bank, out-of-range handling
    op(2, 5'd1, 1'b0, 4'hF, 32'h01010101);
    op(2, 5'd5, 1'b0, 4'hF, 32'h05050505);
    op(2, 5'd3, 1'b0, 4'hF, 32'h5555AAAA);
    op(2, 5'd11, 1'b0, 4'hF, 32'hBBBB1111);
    op(2, 5'd13, 1'b0, 4'hF, 32'hDDDDDDDD);
    op(2, 5'd13, 1'b1, 4'h0, 32'h0);
    op(2, 5'd12, 1'b1, 4'h0, 32'h0);
    op(2, 5'd14, 1'b1, 4'hF, 32'hEEEEEEEE);
    op(2, 5'd11, 1'b1, 4'h0, 32'h0);
    op(2, 5'd1, 1'b1, 4'h0, 32'h0);
    op(2, 5'd5, 1'b1, 4'h0, 32'h0);
    repeat (4) @(negedge clk);

    // test 6: reset mid-sweep with a read in flight
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    ifc.addr = 4'd3; ifc.read = 1'b1;
    ifa.addr = 4'd5; ifa.read = 1'b1;
    @(posedge clk);
    #1;
    check("c rvalid before rst", 64'(ifc.rvalid), 64'(1'b1));
    check("c DO before rst", 64'(ifc.DO), 64'h5555AAAA);
    check("a ready mid-sweep", 64'(ifa.ready), 64'(1'b0));
    rst = 1'b0;
    #1;
    check("c rvalid async clr", 64'(ifc.rvalid), 64'(1'b0));
    check("c DO async clr", 64'(ifc.DO), 64'h0);
    check("a DO async clr", 64'(ifa.DO), 64'h0);
    check("b DO async clr", 64'(ifb.DO), 64'h0);
    check("a init_done rst2", 64'(ifa.init_done), 64'(1'b0));
    idle_all();
    @(negedge clk);
    rst = 1'b1;
    sweep_wait("resweep");
    op(0, 5'd3, 1'b1, 4'h0, 32'h0);
    op(1, 5'd2, 1'b1, 4'h0, 32'h0);
    op(2, 5'd3, 1'b1, 4'h0, 32'h0);
    repeat (4) @(negedge clk);

    for (int d = 0; d < 3; d++) check($sformatf("d%0d queue drained", d), 64'(qsize(d)), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
